cpu_sram_arbiter: RTL

CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

---
 rtl/cpu_sram_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cpu_sram_arbiter.sv
// Two-master SRAM-like arbiter: data side has priority, the grant is held until acceptance,
// and responses are routed back in acceptance order through a 1-bit source-ID FIFO.
module cpu_sram_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] ids_q;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;

    logic gnt_i, gnt_d, gnt_req;
    logic full, empty, push, pop, head;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        unique case (state_q)
            LOCK_I: gnt_i = 1'b1;
            LOCK_D: gnt_d = 1'b1;
            default: begin
                gnt_d = data_sram_req;
                gnt_i = !data_sram_req && inst_sram_req;
            end
        endcase
    end

    assign gnt_req  = (gnt_i && inst_sram_req) || (gnt_d && data_sram_req);
    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    // Outputs are gated by resetn so they read zero while reset is held.
    assign sram_req = resetn && gnt_req && !full;
    assign push     = sram_req && sram_addr_ok;
    assign pop      = resetn && sram_data_ok && !empty;
    assign head     = ids_q[rptr_q];

    always_comb begin
        sram_wr    = 1'b0;
        sram_size  = '0;
        sram_wstrb = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (resetn && gnt_i) begin
            sram_wr    = inst_sram_wr;
            sram_size  = inst_sram_size;
            sram_wstrb = inst_sram_wstrb;
            sram_addr  = inst_sram_addr;
            sram_wdata = inst_sram_wdata;
        end else if (resetn && gnt_d) begin
            sram_wr    = data_sram_wr;
            sram_size  = data_sram_size;
            sram_wstrb = data_sram_wstrb;
            sram_addr  = data_sram_addr;
            sram_wdata = data_sram_wdata;
        end
    end

    assign inst_sram_addr_ok = push && gnt_i;
    assign data_sram_addr_ok = push && gnt_d;
    assign inst_sram_data_ok = pop && !head;
    assign data_sram_data_ok = pop && head;
    assign inst_sram_rdata   = sram_rdata;
    assign data_sram_rdata   = sram_rdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_req && !push) state_d = gnt_d ? LOCK_D : LOCK_I;
            LOCK_I:  if (push || !inst_sram_req) state_d = IDLE;
            LOCK_D:  if (push || !data_sram_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ids_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) begin
                ids_q[wptr_q] <= gnt_d;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule
